// File: rtl/bridge_tx.sv
// bridge_tx - return path of the UART bridge.
//
// Serialises each bus read response as the ASCII frame
//   'D', four uppercase hex digits (most significant nibble first), 0x0D, 0x0A
// toward uart_tx through a registered valid/ready byte stream. A one-entry
// pending buffer absorbs a response that arrives while a frame is in flight.
// If a response arrives while that buffer is already full, it is dropped and
// overflow_o pulses for one cycle.
//
// Optional feature (macro BRIDGE_TX_WRITE_ACK_EN):
//   defined   - write responses emit the 3-byte acknowledge 'K', 0x0D, 0x0A.
//               They share the pending buffer and the overflow rules with reads.
//   undefined - write responses are ignored entirely.
//
// Ports:
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   data_i      in  16   bus response data
//   rw_i        in   1   0 = read response, 1 = write response
//   valid_i     in   1   single-cycle response strobe, no backpressure
//   data_o      out  8   byte to uart_tx (registered)
//   valid_o     out  1   data_o valid (registered)
//   ready_i     in   1   uart_tx accepts byte when valid_o && ready_i
//   busy_o      out  1   frame in progress or pending entry held
//   overflow_o  out  1   one-cycle pulse when a response is dropped
module bridge_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        overflow_o
);

`ifdef BRIDGE_TX_WRITE_ACK_EN
    typedef enum logic [3:0] {
        ST_IDLE, ST_PREAMBLE, ST_NIB3, ST_NIB2, ST_NIB1, ST_NIB0, ST_CR, ST_LF, ST_ACK
    } state_t;
`else
    typedef enum logic [3:0] {
        ST_IDLE, ST_PREAMBLE, ST_NIB3, ST_NIB2, ST_NIB1, ST_NIB0, ST_CR, ST_LF
    } state_t;
`endif

    state_t      r_state;
    logic [15:0] r_word;
    logic        r_pend_valid;
    logic [15:0] r_pend_word;
    logic        r_pend_wr;
    logic [7:0]  r_data_o;
    logic        r_valid_o;
    logic        r_overflow;

    state_t      w_state_next;
    logic [15:0] w_word_next;
    logic        w_pend_valid_next;
    logic [15:0] w_pend_word_next;
    logic        w_pend_wr_next;
    logic        w_drop;
    logic        w_fire;
    logic        w_new;
    logic        w_new_wr;

`ifdef BRIDGE_TX_WRITE_ACK_EN
    assign w_new    = valid_i;
    assign w_new_wr = rw_i;
`else
    // Writes never enter the bridge, so the pending type bit stays zero.
    assign w_new    = valid_i && !rw_i;
    assign w_new_wr = 1'b0;
`endif

    assign w_fire = r_valid_o && ready_i;

    // First state of a frame, chosen by the response type.
    function automatic state_t start_state(input logic is_wr);
`ifdef BRIDGE_TX_WRITE_ACK_EN
        return is_wr ? ST_ACK : ST_PREAMBLE;
`else
        return is_wr ? ST_IDLE : ST_PREAMBLE;
`endif
    endfunction

    function automatic state_t advance(input state_t s);
        case (s)
            ST_PREAMBLE: return ST_NIB3;
            ST_NIB3:     return ST_NIB2;
            ST_NIB2:     return ST_NIB1;
            ST_NIB1:     return ST_NIB0;
            ST_NIB0:     return ST_CR;
            ST_CR:       return ST_LF;
`ifdef BRIDGE_TX_WRITE_ACK_EN
            ST_ACK:      return ST_CR;
`endif
            default:     return ST_IDLE;
        endcase
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] byte_of(input state_t s, input logic [15:0] w);
        case (s)
            ST_PREAMBLE: return 8'h44;
            ST_NIB3:     return hex_char(w[15:12]);
            ST_NIB2:     return hex_char(w[11:8]);
            ST_NIB1:     return hex_char(w[7:4]);
            ST_NIB0:     return hex_char(w[3:0]);
            ST_CR:       return 8'h0D;
            ST_LF:       return 8'h0A;
`ifdef BRIDGE_TX_WRITE_ACK_EN
            ST_ACK:      return 8'h4B;
`endif
            default:     return 8'h00;
        endcase
    endfunction

    always_comb begin
        w_state_next      = r_state;
        w_word_next       = r_word;
        w_pend_valid_next = r_pend_valid;
        w_pend_word_next  = r_pend_word;
        w_pend_wr_next    = r_pend_wr;
        w_drop            = 1'b0;

        if (r_state == ST_IDLE) begin
            // Pending is always empty in IDLE, so a new response starts at once.
            if (w_new) begin
                w_word_next  = data_i;
                w_state_next = start_state(w_new_wr);
            end
        end else if (w_fire && (r_state == ST_LF)) begin
            // Frame ends: the pending entry beats a simultaneous new response,
            // which then takes the slot the pending entry just vacated.
            if (r_pend_valid) begin
                w_word_next       = r_pend_word;
                w_state_next      = start_state(r_pend_wr);
                w_pend_valid_next = w_new;
                if (w_new) begin
                    w_pend_word_next = data_i;
                    w_pend_wr_next   = w_new_wr;
                end
            end else if (w_new) begin
                w_word_next  = data_i;
                w_state_next = start_state(w_new_wr);
            end else begin
                w_state_next = ST_IDLE;
            end
        end else begin
            if (w_fire) begin
                w_state_next = advance(r_state);
            end
            if (w_new) begin
                if (!r_pend_valid) begin
                    w_pend_valid_next = 1'b1;
                    w_pend_word_next  = data_i;
                    w_pend_wr_next    = w_new_wr;
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_word       <= 16'h0000;
            r_pend_valid <= 1'b0;
            r_pend_word  <= 16'h0000;
            r_pend_wr    <= 1'b0;
            r_data_o     <= 8'h00;
            r_valid_o    <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_word       <= w_word_next;
            r_pend_valid <= w_pend_valid_next;
            r_pend_word  <= w_pend_word_next;
            r_pend_wr    <= w_pend_wr_next;
            // The byte for the upcoming state is precomputed so both outputs
            // come straight from flops.
            r_data_o     <= byte_of(w_state_next, w_word_next);
            r_valid_o    <= (w_state_next != ST_IDLE);
            r_overflow   <= w_drop;
        end
    end

    assign data_o     = r_data_o;
    assign valid_o    = r_valid_o;
    assign overflow_o = r_overflow;
    assign busy_o     = (r_state != ST_IDLE) || r_pend_valid;

endmodule
